// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC sequencer: state encoding, defaults
// and a constant-evaluable ceil(log2) helper.
package neuron_pkg;

   localparam int DEF_N            = 1;
   localparam int DEF_MULT_LATENCY = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      RESULT = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// 1-bit strobe delay line with asynchronous clear; depth 0 is a plain wire.
module ctrl_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   if (DEPTH == 0) begin : g_wire
      assign dout = din;
   end else begin : g_shift
      logic [DEPTH-1:0] sr;

      // shift towards the MSB; the MSB is the oldest sample
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sr <= '0;
         end else begin
            sr <= (sr << 1) | DEPTH'(din);
         end
      end

      assign dout = sr[DEPTH-1];
   end

endmodule

// File: rtl/neuron_sequencer.sv
// Fetch/strobe sequencer in front of the neuron MAC datapath: reads N operand
// pairs, times the datapath load strobes and holds the result until acked.
module neuron_sequencer
   import neuron_pkg::*;
#(
   parameter int N            = DEF_N,
   parameter int MULT_LATENCY = DEF_MULT_LATENCY,
   parameter int ADDR_W       = (clog2(N) > 1) ? clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              clr_acc,
   output logic              ldIn,
   output logic              ldWeight,
   output logic              ldNReg,
   output logic              count_up,
   input  logic              count_cout,
   output logic              ready,
   output logic              out_valid,
   input  logic              out_ack,
   output logic              cnt_err
);

   // D covers the operand register stage, the multiplier and the accumulator load
   localparam int D  = 2 + MULT_LATENCY;
   localparam int DW = clog2(D + 1);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N - 1);
   localparam logic [DW-1:0]     LAST_DRAIN = DW'(D - 1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] idx;
   logic [DW-1:0]     drain_cnt;
   logic              err_reg;
   logic              first_result;
   logic              ld_operands;
   logic              ld_accum;

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      rd_en      = 1'b0;
      clr_acc    = 1'b0;
      ready      = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !rst) begin
               clr_acc    = 1'b1;
               state_next = FETCH;
            end else begin
               state_next = IDLE;
            end
         end
         FETCH: begin
            busy  = 1'b1;
            rd_en = 1'b1;
            if (idx == LAST_IDX) begin
               state_next = DRAIN;
            end else begin
               state_next = FETCH;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_cnt == LAST_DRAIN) begin
               state_next = RESULT;
            end else begin
               state_next = DRAIN;
            end
         end
         RESULT: begin
            ready     = 1'b1;
            out_valid = 1'b1;
            if (out_ack) begin
               state_next = IDLE;
            end else begin
               state_next = RESULT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign rd_addr = rd_en ? idx : '0;
   // the first RESULT cycle reports a short count immediately, then the flag holds it
   assign cnt_err = err_reg | (first_result & ~count_cout);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         drain_cnt    <= '0;
         first_result <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state        <= state_next;
         idx          <= (state == FETCH && idx != LAST_IDX) ? idx + 1'b1 : '0;
         drain_cnt    <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
         first_result <= (state_next == RESULT) && (state != RESULT);
         if (clr_acc) begin
            err_reg <= 1'b0;
         end else if (first_result && !count_cout) begin
            err_reg <= 1'b1;
         end
      end
   end

   ctrl_delay_line #(.DEPTH(1)) u_dl_operands (
      .clk  (clk),
      .rst  (rst),
      .din  (rd_en),
      .dout (ld_operands)
   );

   ctrl_delay_line #(.DEPTH(D)) u_dl_accum (
      .clk  (clk),
      .rst  (rst),
      .din  (rd_en),
      .dout (ld_accum)
   );

   assign ldIn     = ld_operands;
   assign ldWeight = ld_operands;
   assign ldNReg   = ld_accum;
   assign count_up = ld_accum;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer: a timestamp model of each run is
// compared every cycle, plus hand-computed spot checks.
module tb_neuron_sequencer;

   localparam int NA  = 4;
   localparam int MLA = 1;
   localparam int NB  = 1;
   localparam int MLB = 0;
   localparam int INF = 1000000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic start_a = 1'b0, ack_a = 1'b0, start_b = 1'b0, ack_b = 1'b0;
   logic busy_a, rd_en_a, clr_a, ldin_a, ldw_a, ldn_a, cu_a, cout_a, ready_a, ov_a, err_a;
   logic busy_b, rd_en_b, clr_b, ldin_b, ldw_b, ldn_b, cu_b, cout_b, ready_b, ov_b, err_b;
   logic [1:0] rd_addr_a;
   logic [0:0] rd_addr_b;

   neuron_sequencer #(.N(NA), .MULT_LATENCY(MLA)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .rd_en(rd_en_a),
      .rd_addr(rd_addr_a), .clr_acc(clr_a), .ldIn(ldin_a), .ldWeight(ldw_a),
      .ldNReg(ldn_a), .count_up(cu_a), .count_cout(cout_a), .ready(ready_a),
      .out_valid(ov_a), .out_ack(ack_a), .cnt_err(err_a)
   );

   neuron_sequencer #(.N(NB), .MULT_LATENCY(MLB)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .rd_en(rd_en_b),
      .rd_addr(rd_addr_b), .clr_acc(clr_b), .ldIn(ldin_b), .ldWeight(ldw_b),
      .ldNReg(ldn_b), .count_up(cu_b), .count_cout(cout_b), .ready(ready_b),
      .out_valid(ov_b), .out_ack(ack_b), .cnt_err(err_b)
   );

   // datapath element counter stand-in; force0_a pins cout low to model a fault
   int dp_cnt_a, dp_cnt_b;
   logic force0_a = 1'b0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_cnt_a <= 0;
         dp_cnt_b <= 0;
      end else begin
         if (clr_a) dp_cnt_a <= 0; else if (cu_a) dp_cnt_a <= dp_cnt_a + 1;
         if (clr_b) dp_cnt_b <= 0; else if (cu_b) dp_cnt_b <= dp_cnt_b + 1;
      end
   end
   assign cout_a = !force0_a && (dp_cnt_a == NA);
   assign cout_b = (dp_cnt_b == NB);

   logic [11:0] act [2];
   logic [1:0]  stv, akv, cov;
   assign act[0] = {busy_a, rd_en_a, rd_addr_a, clr_a, ldin_a, ldw_a, ldn_a, cu_a, ready_a, ov_a, err_a};
   assign act[1] = {busy_b, rd_en_b, 1'b0, rd_addr_b, clr_b, ldin_b, ldw_b, ldn_b, cu_b, ready_b, ov_b, err_b};
   assign stv = {start_b, start_a};
   assign akv = {ack_b, ack_a};
   assign cov = {cout_b, cout_a};

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // model of each run: f = first fetch cycle, ackc = cycle the ack was taken
   bit run [2] = '{1'b0, 1'b0};
   int f [2]    = '{0, 0};
   int ackc [2] = '{INF, INF};
   bit err [2]  = '{1'b0, 1'b0};

   function automatic int pn(input int k);
      return (k == 0) ? NA : NB;
   endfunction

   function automatic int pd(input int k);
      return (k == 0) ? 2 + MLA : 2 + MLB;
   endfunction

   function automatic bit idle(input int k, input int c);
      return !run[k] || (c > ackc[k]);
   endfunction

   // advance the model with the inputs sampled at this edge
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            run[k] = 1'b0;
            err[k] = 1'b0;
         end else if (idle(k, cyc) && stv[k]) begin
            run[k]  = 1'b1;
            f[k]    = cyc + 1;
            ackc[k] = INF;
            err[k]  = 1'b0;
         end else if (run[k] && cyc >= f[k] + pn(k) + pd(k) && cyc <= ackc[k] && akv[k]) begin
            ackc[k] = cyc;
         end
      end
      cyc = cyc + 1;
   end

   task automatic check_dut(input int k);
      int n, d, c, addr;
      bit rde, lin, ldn, bsy, res, clr, first, ce;
      logic [11:0] expv;
      n = pn(k);
      d = pd(k);
      c = cyc;
      if (rst) begin
         expv = '0;
      end else begin
         rde   = run[k] && c >= f[k] && c < f[k] + n;
         addr  = rde ? c - f[k] : 0;
         lin   = run[k] && c >= f[k] + 1 && c < f[k] + n + 1;
         ldn   = run[k] && c >= f[k] + d && c < f[k] + d + n;
         bsy   = run[k] && c >= f[k] && c < f[k] + n + d;
         res   = run[k] && c >= f[k] + n + d && c <= ackc[k];
         clr   = idle(k, c) && stv[k];
         first = run[k] && c == f[k] + n + d;
         ce    = err[k] || (first && !cov[k]);
         if (first && !cov[k]) err[k] = 1'b1;
         expv  = {bsy, rde, 2'(addr), clr, lin, lin, ldn, ldn, res, res, ce};
      end
      n_checks++;
      if (act[k] !== expv) begin
         n_errors++;
         $display("FAIL outputs dut%0d cycle %0d got %b want %b", k, c, act[k], expv);
      end
   endtask

   // compare both DUTs against the model mid-cycle
   always @(negedge clk) begin
      check_dut(0);
      check_dut(1);
   end

   task automatic chk(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_busy", busy_a, 0);
      chk("reset_ov", ov_a, 0);
      chk("reset_addr", rd_addr_a, 0);
      chk("reset_err", err_a, 0);
      rst = 1'b0;
      tick();

      // scenario 1: basic N=4 timing
      start_a = 1'b1;
      #1 chk("s1_clr_start", clr_a, 1);
      tick(); start_a = 1'b0;
      chk("s1_clr_off", clr_a, 0);
      chk("s1_addr0", rd_addr_a, 0);
      repeat (2) tick();
      chk("s1_addr2", rd_addr_a, 2);
      chk("s1_ldin", ldin_a, 1);
      tick();
      chk("s1_ldn_first", ldn_a, 1);
      repeat (3) tick();
      chk("s1_ov_before", ov_a, 0);
      chk("s1_ldn_last", ldn_a, 1);
      tick();
      chk("s1_ov_rise", ov_a, 1);
      chk("s1_ready_rise", ready_a, 1);
      chk("s1_busy_off", busy_a, 0);

      // scenario 2: long hold with start asserted during RESULT
      start_a = 1'b1;
      repeat (10) tick();
      chk("s2_hold_ov", ov_a, 1);
      chk("s2_no_fetch", rd_en_a, 0);
      start_a = 1'b0; ack_a = 1'b1;
      tick(); ack_a = 1'b0;
      chk("s2_idle_ov", ov_a, 0);
      chk("s2_idle_ready", ready_a, 0);
      tick();

      // scenario 3: counter mismatch is sticky until the next start
      force0_a = 1'b1; start_a = 1'b1;
      tick(); start_a = 1'b0;
      repeat (7) tick();
      chk("s3_err_first", err_a, 1);
      repeat (2) tick();
      ack_a = 1'b1;
      tick(); ack_a = 1'b0;
      repeat (3) tick();
      chk("s3_err_idle", err_a, 1);
      force0_a = 1'b0; start_a = 1'b1;
      tick(); start_a = 1'b0;
      chk("s3_err_cleared", err_a, 0);
      repeat (7) tick();
      chk("s3_err_good_run", err_a, 0);
      ack_a = 1'b1;
      tick(); ack_a = 1'b0;
      tick();

      // scenario 4: reset during FETCH, then a clean run
      start_a = 1'b1;
      tick(); start_a = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      chk("s4_rst_rd_en", rd_en_a, 0);
      chk("s4_rst_busy", busy_a, 0);
      chk("s4_rst_addr", rd_addr_a, 0);
      chk("s4_rst_ldin", ldin_a, 0);
      tick(); rst = 1'b0;
      tick();
      start_a = 1'b1;
      tick(); start_a = 1'b0;
      chk("s4_restart_rd_en", rd_en_a, 1);
      chk("s4_restart_addr", rd_addr_a, 0);
      repeat (7) tick();
      chk("s4_ov", ov_a, 1);
      ack_a = 1'b1;
      tick(); ack_a = 1'b0;
      tick();

      // scenario 5: N=1, zero multiplier latency
      start_b = 1'b1;
      tick(); start_b = 1'b0;
      chk("s5_rd_en", rd_en_b, 1);
      chk("s5_addr", rd_addr_b, 0);
      tick();
      chk("s5_ldin", ldin_b, 1);
      chk("s5_rd_en_off", rd_en_b, 0);
      tick();
      chk("s5_ldn", ldn_b, 1);
      chk("s5_ov_before", ov_b, 0);
      tick();
      chk("s5_ov", ov_b, 1);
      ack_b = 1'b1;
      tick(); ack_b = 1'b0;
      chk("s5_ov_off", ov_b, 0);
      tick();

      // scenario 6: back-to-back runs
      start_a = 1'b1;
      tick(); start_a = 1'b0;
      repeat (7) tick();
      ack_a = 1'b1;
      tick(); ack_a = 1'b0; start_a = 1'b1;
      #1 chk("s6_clr_second", clr_a, 1);
      tick(); start_a = 1'b0;
      chk("s6_addr0", rd_addr_a, 0);
      repeat (3) tick();
      chk("s6_ldn", ldn_a, 1);
      repeat (4) tick();
      chk("s6_ov", ov_a, 1);
      ack_a = 1'b1;
      tick(); ack_a = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
- Control stage directly upstream of the neuron MAC datapath.
- On a start request, fetches N (input, weight) byte pairs from synchronous read memories (1-cycle read latency) and drives the datapath load/accumulate strobes, timed to the datapath's register and multiplier pipeline.
- Holds the datapath's `ready` (activation enable) high until the downstream consumer acknowledges the result.
- Cross-checks the datapath's element counter for verification.

Parameters:
- N, 1: number of vector elements per neuron evaluation (≥1).
- MULT_LATENCY, 1: multiplier core output latency in cycles (≥0).
- ADDR_W, max(1, clog2(N)): memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new evaluation; sampled only in IDLE.
- busy  out  1  high in FETCH and DRAIN.
- rd_en  out  1  read enable to input and weight memories.
- rd_addr  out  ADDR_W  shared read address; data valid on the following cycle.
- clr_acc  out  1  one-cycle pulse clearing datapath accumulator and element counter.
- ldIn  out  1  load input register in datapath.
- ldWeight  out  1  load weight register in datapath.
- ldNReg  out  1  load accumulator register in datapath.
- count_up  out  1  increment datapath element counter.
- count_cout  in  1  datapath counter terminal flag.
- ready  out  1  activation enable to datapath.
- out_valid  out  1  result available on datapath outActive.
- out_ack  in  1  consumer accepts result.
- cnt_err  out  1  sticky counter mismatch flag.

Behaviour:
- Reset: state = IDLE. All outputs are 0, rd_addr = 0, cnt_err = 0, and the delay pipelines are cleared. Reset asserted mid-operation aborts immediately with no partial result.
- States: IDLE, FETCH, DRAIN, RESULT.
- IDLE:
  - start = 1 → clr_acc = 1 this cycle, element index idx ← 0, go to FETCH.
  - cnt_err clears on this accepted start.
  - start in any other state is ignored.
- FETCH (exactly N cycles):
  - rd_en = 1, rd_addr = idx, idx increments every cycle.
  - After the cycle with idx = N-1, go to DRAIN.
  - Addresses never exceed N-1; no wrap is issued.
- Strobe timing, with cycle 0 = first FETCH cycle:
  - ldIn = ldWeight = rd_en delayed 1 cycle.
  - ldNReg = count_up = rd_en delayed D = 2+MULT_LATENCY cycles.
  - One element per cycle, fully pipelined, no bubbles.
  - Delay lines are shift registers and are not gated by state.
- DRAIN: lasts exactly D cycles, until the last ldNReg pulse has been issued, then go to RESULT.
- RESULT:
  - ready = 1 and out_valid = 1, held until out_ack = 1, then IDLE on the next cycle.
  - ready and out_valid drop in that IDLE cycle.
  - out_ack outside RESULT is ignored.
  - start and out_ack in the same RESULT cycle: ack is taken, start is ignored.
- Counter check: on the first RESULT cycle, sample count_cout. If it is 0, set cnt_err = 1 (sticky until the next accepted start).
- Latency: out_valid rises at cycle N+D (from first FETCH cycle), i.e. N+D+1 cycles after the start edge.
- N = 1: FETCH lasts one cycle; all rules are unchanged.
- busy = 1 exactly in FETCH and DRAIN.

Decomposition:
- Shared package neuron_pkg:
  - state encoding constants (IDLE = 0, FETCH = 1, DRAIN = 2, RESULT = 3);
  - clog2 function;
  - default N, MULT_LATENCY.
- One sub-module: ctrl_delay_line (parameter DEPTH, 1-bit shift register with async active-high clear), instantiated twice, for depth 1 and depth D.
  - DEPTH = 0 passes through combinationally.
- FSM, index counter and check logic live in the top module.

Test Plan:
1. N=4, MULT_LATENCY=1, start pulse at edge k (cycle 0 = k+1):
   - rd_en high cycles 0–3 with rd_addr 0,1,2,3;
   - ldIn/ldWeight high cycles 1–4;
   - ldNReg/count_up high cycles 3–6;
   - out_valid and ready rise at cycle 7;
   - clr_acc pulses only at cycle -1 (start cycle).
2. Same configuration, out_ack held low for 10 cycles then pulsed:
   - out_valid and ready stay 1 throughout;
   - IDLE one cycle after ack, outputs 0;
   - start held high during RESULT causes no new fetch.
3. Datapath model holds count_cout = 0:
   - cnt_err = 1 from the first RESULT cycle and stays 1 through IDLE;
   - cleared by the next accepted start.
4. rst asserted at cycle 2 of FETCH:
   - all outputs 0 asynchronously, state IDLE;
   - a following start produces a full, correct sequence beginning at rd_addr 0.
5. N=1, MULT_LATENCY=0 (D=2):
   - one rd_en at addr 0;
   - ldIn at cycle 1, ldNReg at cycle 2, out_valid at cycle 3.
6. Back-to-back runs: out_ack and a start on the next IDLE cycle:
   - second run timing identical to scenario 1;
   - clr_acc pulses once per run.
